image_line_fifo: RTL

IMAGE_LINE_FIFO -- requirements
Module: image_line_fifo

---
 rtl/image_line_fifo_if.sv | 31 +++
 rtl/image_line_fifo.sv | 117 +++++++++++
 2 files changed

// File: rtl/image_line_fifo_if.sv
// Pixel-stream FIFO port bundle: write/read handshake plus status and sticky error flags.
// master drives writes and read requests; slave is the FIFO itself.
interface image_line_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1024
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] din;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic              full;
  logic              empty;
  logic              prog_full;
  logic [CW-1:0]     data_count;
  logic              line_avail;
  logic              overflow;
  logic              underflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, valid, full, empty, prog_full, data_count, line_avail, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, valid, full, empty, prog_full, data_count, line_avail, overflow, underflow
  );
endinterface

// File: rtl/image_line_fifo.sv
// Single-clock line-buffer FIFO with standard or first-word-fall-through read mode,
// registered status flags, line-available indication and sticky overflow/underflow.
module image_line_fifo #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned LINE_LEN     = 640,
  parameter int unsigned PROG_FULL_TH = 960,
  parameter bit          FWFT         = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  input logic              srst,
  image_line_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
  localparam logic [CW-1:0] LineTh  = CW'(LINE_LEN);
  localparam logic [CW-1:0] PfTh    = CW'(PROG_FULL_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q, byp_q;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, empty_q, prog_full_q, line_avail_q;
  logic              valid_q, valid_d, ovf_q, udf_q, loaded_q, src_byp_q;
  logic              rd_acc, wr_acc, mem_empty, need_load, ram_re, bypass, mem_we;

  always_comb begin
    rd_acc    = bus.rd_en && !empty_q && !srst;
    // A read at full frees a slot at the same edge, so the paired write is kept.
    wr_acc    = bus.wr_en && (!full_q || rd_acc) && !srst;
    mem_empty = (wr_ptr_q == rd_ptr_q);
    need_load = 1'b0;
    ram_re    = 1'b0;
    bypass    = 1'b0;
    valid_d   = 1'b0;
    if (FWFT) begin
      // Output stage refills from RAM if possible, otherwise straight from din.
      need_load = !valid_q || rd_acc;
      ram_re    = need_load && !mem_empty && !srst;
      bypass    = need_load && mem_empty && wr_acc;
      valid_d   = ram_re || bypass || (valid_q && !rd_acc);
    end else begin
      ram_re  = rd_acc;
      valid_d = rd_acc;
    end
    mem_we   = wr_acc && !bypass;
    wr_ptr_d = wr_ptr_q + PW'(mem_we);
    rd_ptr_d = rd_ptr_q + PW'(ram_re);
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (ram_re) ram_q <= mem[rd_ptr_q[AW-1:0]];
    if (bypass) byp_q <= bus.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      prog_full_q  <= 1'b0;
      line_avail_q <= 1'b0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      loaded_q     <= 1'b0;
      src_byp_q    <= 1'b0;
    end else if (srst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      prog_full_q  <= 1'b0;
      line_avail_q <= 1'b0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= (count_d == FullCnt);
      empty_q      <= (count_d == '0);
      prog_full_q  <= (count_d >= PfTh);
      line_avail_q <= (count_d >= LineTh);
      valid_q      <= valid_d;
      ovf_q        <= ovf_q || (bus.wr_en && !wr_acc);
      udf_q        <= udf_q || (bus.rd_en && empty_q);
      if (ram_re || bypass) begin
        loaded_q  <= 1'b1;
        src_byp_q <= bypass;
      end
    end
  end

  // dout reads as zero until the first word has ever been loaded after reset.
  assign bus.dout       = !loaded_q ? '0 : (src_byp_q ? byp_q : ram_q);
  assign bus.valid      = valid_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.prog_full  = prog_full_q;
  assign bus.line_avail = line_avail_q;
  assign bus.data_count = count_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = udf_q;
endmodule
